// File: rtl/sobel_edge_pp.sv
// sobel_edge_pp: 4-stage Sobel gradient, magnitude, direction and
// per-frame edge counter with frame-synchronous config shadowing.
module sobel_edge_pp #(
    parameter int DATA_W         = 8,
    parameter int THRESH_DEFAULT = 28,
    parameter int CNT_W          = 24
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic              matrix_de,
    input  logic              matrix_vs,
    input  logic [DATA_W-1:0] matrix11,
    input  logic [DATA_W-1:0] matrix12,
    input  logic [DATA_W-1:0] matrix13,
    input  logic [DATA_W-1:0] matrix21,
    input  logic [DATA_W-1:0] matrix22,
    input  logic [DATA_W-1:0] matrix23,
    input  logic [DATA_W-1:0] matrix31,
    input  logic [DATA_W-1:0] matrix32,
    input  logic [DATA_W-1:0] matrix33,
    input  logic [DATA_W+2:0] cfg_threshold,
    input  logic [1:0]        cfg_mode,
    output logic              sobel_vs,
    output logic              sobel_de,
    output logic [DATA_W-1:0] sobel_data,
    output logic [1:0]        sobel_dir,
    output logic [CNT_W-1:0]  edge_count,
    output logic              frame_done
);

    localparam int GW = DATA_W + 2;
    localparam int MW = DATA_W + 3;
    localparam logic [DATA_W-1:0] PIX_ONES = {DATA_W{1'b1}};
    localparam logic [MW-1:0]     PIX_MAX  = {3'b000, PIX_ONES};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // 1-2-1 weighted column/row sum
    function automatic logic [GW-1:0] wsum(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] c
    );
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // config shadow
    logic              vs_prev_q;
    logic [MW-1:0]     thr_act_q;
    logic [1:0]        mode_act_q;
    logic              vs_rise_in;

    // stage 1
    logic [GW-1:0]     gxp_d, gxn_d, gyp_d, gyn_d;
    logic [GW-1:0]     gxp_q, gxn_q, gyp_q, gyn_q;
    logic              de1_q, vs1_q;

    // stage 2
    logic [GW-1:0]     ax_d, ay_d;
    logic              sx_d, sy_d;
    logic [GW-1:0]     ax_q, ay_q;
    logic              sx_q, sy_q;
    logic              de2_q, vs2_q;

    // stage 3
    logic [GW-1:0]     mx, mn;
    logic [MW-1:0]     mag_l1, mag_l2;
    logic [MW-1:0]     mag_d;
    logic [1:0]        dir_d;
    logic [MW-1:0]     mag_q;
    logic [1:0]        dir_q;
    logic              de3_q, vs3_q;

    // stage 4
    logic              hit;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        dir4_d;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        dir4_q;
    logic              de4_q, vs4_q;

    // edge counter
    logic              vs_rise4;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  edge_count_d, edge_count_q;
    logic              frame_done_d, frame_done_q;

    assign vs_rise_in = matrix_vs & ~vs_prev_q;

    // latch runtime config only on a frame-start edge
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q  <= 1'b0;
            thr_act_q  <= MW'(THRESH_DEFAULT);
            mode_act_q <= 2'b00;
        end else begin
            vs_prev_q <= matrix_vs;
            if (vs_rise_in) begin
                thr_act_q  <= cfg_threshold;
                mode_act_q <= cfg_mode;
            end
        end
    end

    // S1: positive/negative kernel halves, gated by de
    always_comb begin
        gxp_d = '0;
        gxn_d = '0;
        gyp_d = '0;
        gyn_d = '0;
        if (matrix_de) begin
            gxp_d = wsum(matrix13, matrix23, matrix33);
            gxn_d = wsum(matrix11, matrix21, matrix31);
            gyp_d = wsum(matrix11, matrix12, matrix13);
            gyn_d = wsum(matrix31, matrix32, matrix33);
        end
    end

    // S1 register
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            gxp_q <= '0;
            gxn_q <= '0;
            gyp_q <= '0;
            gyn_q <= '0;
            de1_q <= 1'b0;
            vs1_q <= 1'b0;
        end else begin
            gxp_q <= gxp_d;
            gxn_q <= gxn_d;
            gyp_q <= gyp_d;
            gyn_q <= gyn_d;
            de1_q <= matrix_de;
            vs1_q <= matrix_vs;
        end
    end

    // S2: absolute gradients and their signs
    always_comb begin
        sx_d = gxp_q < gxn_q;
        sy_d = gyp_q < gyn_q;
        ax_d = sx_d ? (gxn_q - gxp_q) : (gxp_q - gxn_q);
        ay_d = sy_d ? (gyn_q - gyp_q) : (gyp_q - gyn_q);
    end

    // S2 register
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q  <= '0;
            ay_q  <= '0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
            de2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            ax_q  <= ax_d;
            ay_q  <= ay_d;
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            de2_q <= de1_q;
            vs2_q <= vs1_q;
        end
    end

    // S3: magnitude norm and direction classification
    always_comb begin
        mx     = (ax_q >= ay_q) ? ax_q : ay_q;
        mn     = (ax_q >= ay_q) ? ay_q : ax_q;
        mag_l1 = {1'b0, ax_q} + {1'b0, ay_q};
        mag_l2 = {1'b0, mx} + {2'b00, mn[GW-1:1]};
        mag_d  = mode_act_q[1] ? mag_l2 : mag_l1;
        if ({1'b0, ax_q} >= {ay_q, 1'b0}) begin
            dir_d = 2'd0;
        end else if ({1'b0, ay_q} >= {ax_q, 1'b0}) begin
            dir_d = 2'd1;
        end else if (sx_q == sy_q) begin
            dir_d = 2'd2;
        end else begin
            dir_d = 2'd3;
        end
    end

    // S3 register
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            dir_q <= 2'd0;
            de3_q <= 1'b0;
            vs3_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            dir_q <= dir_d;
            de3_q <= de2_q;
            vs3_q <= vs2_q;
        end
    end

    // S4: binary/gray output pixel, blanked outside de
    always_comb begin
        hit    = de3_q && (mag_q >= thr_act_q);
        data_d = '0;
        dir4_d = 2'd0;
        if (de3_q) begin
            dir4_d = dir_q;
            if (mode_act_q[0]) begin
                data_d = (mag_q > PIX_MAX) ? PIX_ONES
                                           : mag_q[DATA_W-1:0];
            end else begin
                data_d = hit ? PIX_ONES : '0;
            end
        end
    end

    // S4 register
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dir4_q <= 2'd0;
            de4_q  <= 1'b0;
            vs4_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir4_q <= dir4_d;
            de4_q  <= de3_q;
            vs4_q  <= vs3_q;
        end
    end

    // running count; publish and restart on output frame start
    always_comb begin
        vs_rise4     = vs3_q & ~vs4_q;
        edge_count_d = edge_count_q;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        if (vs_rise4) begin
            edge_count_d = cnt_q;
            frame_done_d = 1'b1;
            cnt_d        = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // counter registers
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            edge_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            edge_count_q <= edge_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sobel_vs   = vs4_q;
    assign sobel_de   = de4_q;
    assign sobel_data = data_q;
    assign sobel_dir  = dir4_q;
    assign edge_count = edge_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_edge_pp.sv
// tb_sobel_edge_pp: scoreboard bench, directed plus random frames
// checked against an arithmetic Sobel reference model.
module tb_sobel_edge_pp;

    logic        video_clk;
    logic        rst_n;
    logic        matrix_de;
    logic        matrix_vs;
    logic [7:0]  m [9];
    logic [10:0] cfg_threshold;
    logic [1:0]  cfg_mode;
    logic        sobel_vs;
    logic        sobel_de;
    logic [7:0]  sobel_data;
    logic [1:0]  sobel_dir;
    logic [23:0] edge_count;
    logic        frame_done;

    typedef struct {
        int cyc;
        int data;
        int dir;
    } pexp_t;

    typedef struct {
        int cyc;
        int cnt;
    } fexp_t;

    pexp_t pq[$];
    fexp_t fq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_thr    = 28;
    int m_mode   = 0;
    int frame_cnt = 0;
    int win [9];

    sobel_edge_pp #(
        .DATA_W(8),
        .THRESH_DEFAULT(28),
        .CNT_W(24)
    ) dut (
        .video_clk(video_clk),
        .rst_n(rst_n),
        .matrix_de(matrix_de),
        .matrix_vs(matrix_vs),
        .matrix11(m[0]),
        .matrix12(m[1]),
        .matrix13(m[2]),
        .matrix21(m[3]),
        .matrix22(m[4]),
        .matrix23(m[5]),
        .matrix31(m[6]),
        .matrix32(m[7]),
        .matrix33(m[8]),
        .cfg_threshold(cfg_threshold),
        .cfg_mode(cfg_mode),
        .sobel_vs(sobel_vs),
        .sobel_de(sobel_de),
        .sobel_data(sobel_data),
        .sobel_dir(sobel_dir),
        .edge_count(edge_count),
        .frame_done(frame_done)
    );

    initial begin
        video_clk = 1'b0;
        forever #5 video_clk = ~video_clk;
    end

    always @(posedge video_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Sobel reference from the kernel definitions
    function automatic void model(input int w [9], input int thr,
                                  input int mode, output int mag,
                                  output int data, output int dir);
        int gx, gy, ax, ay, mx, mn;
        gx = (w[2] + 2*w[5] + w[8]) - (w[0] + 2*w[3] + w[6]);
        gy = (w[0] + 2*w[1] + w[2]) - (w[6] + 2*w[7] + w[8]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        mag = mode[1] ? (mx + mn/2) : (ax + ay);
        if (ax >= 2*ay) dir = 0;
        else if (ay >= 2*ax) dir = 1;
        else if ((gx < 0) == (gy < 0)) dir = 2;
        else dir = 3;
        if (mode[0]) data = (mag > 255) ? 255 : mag;
        else data = (mag >= thr) ? 255 : 0;
    endfunction

    task automatic set_win(input int a, input int b, input int c,
                           input int d, input int e, input int f,
                           input int g, input int h, input int i);
        win[0] = a; win[1] = b; win[2] = c;
        win[3] = d; win[4] = e; win[5] = f;
        win[6] = g; win[7] = h; win[8] = i;
    endtask

    task automatic issue_win();
        int mag, data, dir;
        pexp_t e;
        @(posedge video_clk);
        #2;
        for (int k = 0; k < 9; k++) m[k] = 8'(win[k]);
        matrix_de = 1'b1;
        matrix_vs = 1'b0;
        model(win, m_thr, m_mode, mag, data, dir);
        e.cyc  = cyc + 4;
        e.data = data;
        e.dir  = dir;
        pq.push_back(e);
        if (mag >= m_thr) frame_cnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge video_clk);
            #2;
            matrix_de = 1'b0;
            matrix_vs = 1'b0;
            for (int j = 0; j < 9; j++) m[j] = 8'($urandom);
        end
    endtask

    task automatic vs_pulse(input int thr, input int mode);
        fexp_t f;
        idle(5);
        cfg_threshold = 11'(thr);
        cfg_mode      = 2'(mode);
        @(posedge video_clk);
        #2;
        matrix_vs = 1'b1;
        matrix_de = 1'b0;
        f.cyc = cyc + 4;
        f.cnt = frame_cnt;
        fq.push_back(f);
        frame_cnt = 0;
        m_thr  = thr;
        m_mode = mode;
        @(posedge video_clk);
        #2;
        matrix_vs = 1'b1;
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge video_clk);
        #2;
        rst_n     = 1'b0;
        matrix_de = 1'b0;
        matrix_vs = 1'b0;
        pq.delete();
        fq.delete();
        m_thr     = 28;
        m_mode    = 0;
        frame_cnt = 0;
        #1;
        chk("rst_de", int'(sobel_de), 0);
        chk("rst_vs", int'(sobel_vs), 0);
        chk("rst_data", int'(sobel_data), 0);
        chk("rst_dir", int'(sobel_dir), 0);
        chk("rst_count", int'(edge_count), 0);
        chk("rst_done", int'(frame_done), 0);
        repeat (2) @(posedge video_clk);
        #2;
        rst_n = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge video_clk) begin
        pexp_t pe;
        fexp_t fe;
        if (rst_n) begin
            if (sobel_de) begin
                if (pq.size() == 0) begin
                    chk("stray_pixel", 1, 0);
                end else begin
                    pe = pq.pop_front();
                    chk("pix_latency", cyc, pe.cyc);
                    chk("pix_data", int'(sobel_data), pe.data);
                    chk("pix_dir", int'(sobel_dir), pe.dir);
                end
            end else begin
                chk("blank_data", int'(sobel_data), 0);
                chk("blank_dir", int'(sobel_dir), 0);
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    chk("stray_frame_done", 1, 0);
                end else begin
                    fe = fq.pop_front();
                    chk("fd_cycle", cyc, fe.cyc);
                    chk("fd_vs_aligned", int'(sobel_vs), 1);
                    chk("edge_count", int'(edge_count), fe.cnt);
                end
            end
        end
    end

    initial begin
        int thr, md, rng;
        rst_n         = 1'b0;
        matrix_de     = 1'b0;
        matrix_vs     = 1'b0;
        cfg_threshold = 11'd28;
        cfg_mode      = 2'd0;
        for (int k = 0; k < 9; k++) m[k] = 8'd0;

        do_reset();
        vs_pulse(28, 0);

        // binary L1, thr 28: 37 edge pixels
        for (int k = 0; k < 20; k++) begin
            set_win(0, 0, 100, 0, 0, 100, 0, 0, 100);
            issue_win();
        end
        for (int k = 0; k < 17; k++) begin
            set_win(0, 0, 0, 0, 0, 0, 10, 10, 10);
            issue_win();
        end
        for (int k = 0; k < 5; k++) begin
            set_win(50, 50, 50, 50, 50, 50, 50, 50, 50);
            issue_win();
        end
        vs_pulse(41, 0);

        // thr 41: horizontal step no longer an edge
        for (int k = 0; k < 5; k++) begin
            set_win(0, 0, 0, 0, 0, 0, 10, 10, 10);
            issue_win();
        end
        set_win(50, 50, 50, 50, 50, 50, 50, 50, 50);
        issue_win();
        vs_pulse(28, 1);

        // gray L1
        set_win(0, 0, 100, 0, 0, 100, 0, 0, 100);
        issue_win();
        set_win(0, 10, 10, 0, 0, 10, 0, 0, 10);
        issue_win();
        set_win(0, 0, 0, 0, 0, 0, 10, 10, 10);
        issue_win();
        vs_pulse(28, 3);

        // gray approx L2
        set_win(0, 10, 10, 0, 0, 10, 0, 0, 10);
        issue_win();
        set_win(50, 50, 50, 50, 50, 50, 50, 50, 50);
        issue_win();
        vs_pulse(28, 0);

        // mid-frame threshold write is ignored until next frame
        set_win(0, 0, 100, 0, 0, 100, 0, 0, 100);
        issue_win();
        cfg_threshold = 11'd500;
        issue_win();
        idle(2);
        issue_win();
        vs_pulse(500, 0);
        issue_win();
        issue_win();

        // random frames
        for (int f = 0; f < 6; f++) begin
            thr = $urandom_range(0, 600);
            md  = $urandom_range(0, 3);
            vs_pulse(thr, md);
            rng = (f % 3 == 0) ? 255 : ((f % 3 == 1) ? 40 : 6);
            for (int c = 0; c < 50; c++) begin
                if (c == 25) begin
                    cfg_threshold = 11'($urandom);
                    cfg_mode      = 2'($urandom);
                end
                if ($urandom_range(0, 9) < 8) begin
                    for (int k = 0; k < 9; k++)
                        win[k] = $urandom_range(0, rng);
                    issue_win();
                end else begin
                    idle(1);
                end
            end
        end

        // reset in the middle of an active line
        vs_pulse(500, 1);
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 9; k++) win[k] = $urandom_range(0, 255);
            issue_win();
        end
        do_reset();

        // default threshold restored, cfg inputs not yet loaded
        set_win(0, 0, 0, 0, 0, 0, 1, 13, 1);
        issue_win();
        set_win(0, 0, 0, 0, 0, 0, 0, 13, 0);
        issue_win();
        vs_pulse(28, 0);
        idle(10);

        chk("pix_queue_empty", pq.size(), 0);
        chk("frame_queue_empty", fq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
